// File: rtl/drone_pkg.sv
// Shared drone-controller types and constants used by the tachometer front end.
package drone_pkg;

    localparam int unsigned NMOT    = 4;
    localparam logic [15:0] RPM_MAX = 16'h157C;

    typedef enum logic [1:0] {
        MOT_L,
        MOT_RT,
        MOT_F,
        MOT_RV
    } mot_e;

    typedef shortint rpm_t;

endpackage

// File: rtl/tach_chan.sv
// One tachometer channel: synchronize, debounce, count rising edges, and
// convert the count to a saturated rpm value plus stall flag at window close.
module tach_chan
    import drone_pkg::*;
#(
    parameter int unsigned RPM_PER_CNT = 25,
    parameter int unsigned DEB         = 2,
    parameter int unsigned STALL_WIN   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic term,
    input  logic tach,
    output rpm_t rpm,
    output logic stall
);

    localparam int unsigned DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int unsigned ZW = $clog2(STALL_WIN + 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          rise;
    logic [15:0]   cnt_q, cnt_d, cnt_inc;
    logic [ZW-1:0] zw_q, zw_d, zw_next;
    logic [31:0]   prod;
    logic [15:0]   scaled;
    rpm_t          rpm_q;
    logic          stall_q;

    // Filter: accept a new level only after DEB consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        dcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (dcnt_q == DW'(DEB - 1)) begin
                filt_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    always_comb begin
        rise    = filt_q & ~filt_prev_q;
        cnt_inc = cnt_q;
        if (rise && (cnt_q != 16'hFFFF)) begin
            cnt_inc = cnt_q + 16'd1;
        end
        // An edge landing in the terminal cycle still belongs to the closing window.
        cnt_d  = (!en || term) ? 16'd0 : cnt_inc;
        prod   = 32'(cnt_inc) * RPM_PER_CNT;
        scaled = (prod > 32'(RPM_MAX)) ? RPM_MAX : prod[15:0];

        zw_next = '0;
        if (cnt_inc == 16'd0) begin
            zw_next = (zw_q == ZW'(STALL_WIN)) ? zw_q : zw_q + ZW'(1);
        end
        zw_d = zw_q;
        if (!en) begin
            zw_d = '0;
        end else if (term) begin
            zw_d = zw_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            dcnt_q      <= '0;
            cnt_q       <= '0;
            zw_q        <= '0;
            rpm_q       <= '0;
            stall_q     <= 1'b0;
        end else begin
            sync1_q     <= tach;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            dcnt_q      <= dcnt_d;
            cnt_q       <= cnt_d;
            zw_q        <= zw_d;
            if (term) begin
                rpm_q   <= rpm_t'(scaled);
                stall_q <= (zw_next == ZW'(STALL_WIN));
            end
        end
    end

    assign rpm   = rpm_q;
    assign stall = stall_q;

endmodule

// File: rtl/rpm_tach.sv
// Tachometer front end: shared measurement window, enable gating and the
// publish strobe around NMOT independent tach channels.
module rpm_tach
    import drone_pkg::*;
#(
    parameter int unsigned WINDOW_CYC  = 8000,
    parameter int unsigned RPM_PER_CNT = 25,
    parameter int unsigned DEB         = 2,
    parameter int unsigned STALL_WIN   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NMOT-1:0] tach,
    output rpm_t            rpm_sense [NMOT],
    output logic            rpm_valid,
    output logic [NMOT-1:0] stall
);

    localparam int unsigned WW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;

    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          term;
    logic          valid_q;

    always_comb begin
        term   = en && (wcnt_q == WW'(WINDOW_CYC - 1));
        wcnt_d = wcnt_q + WW'(1);
        if (!en || term) begin
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            valid_q <= term;
        end
    end

    assign rpm_valid = valid_q;

    for (genvar i = 0; i < NMOT; i++) begin : g_chan
        tach_chan #(
            .RPM_PER_CNT(RPM_PER_CNT),
            .DEB        (DEB),
            .STALL_WIN  (STALL_WIN)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .en   (en),
            .term (term),
            .tach (tach[i]),
            .rpm  (rpm_sense[i]),
            .stall(stall[i])
        );
    end

endmodule

// File: tb/tb_rpm_tach.sv
// Self-checking bench for rpm_tach: per-window tach waveforms are generated up
// front and a run-length pulse model predicts rpm_sense and stall.
module tb_rpm_tach;
    import drone_pkg::*;

    localparam int WIN   = 8000;
    localparam int RPC   = 25;
    localparam int RMAX  = 5500;
    localparam int SW    = 3;
    localparam int DEBN  = 2;
    localparam int CH_L  = int'(MOT_L);
    localparam int CH_RT = int'(MOT_RT);
    localparam int CH_F  = int'(MOT_F);
    localparam int CH_RV = int'(MOT_RV);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic [NMOT-1:0] tach = '0;
    rpm_t            rpm_sense [NMOT];
    logic            rpm_valid;
    logic [NMOT-1:0] stall;

    rpm_tach dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .tach     (tach),
        .rpm_sense(rpm_sense),
        .rpm_valid(rpm_valid),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NMOT-1:0] wave [WIN];
    logic [NMOT-1:0] last_lvl  = '0;
    logic [NMOT-1:0] start_lvl = '0;
    int              exp_rpm  [NMOT];
    logic [NMOT-1:0] exp_stall = '0;
    int              zero_run [NMOT];

    task automatic clear_wave();
        for (int j = 0; j < WIN; j++) wave[j] = '0;
    endtask

    // Clean pulses (high >= DEB, low >= 3), optionally followed by a 1-cycle glitch.
    task automatic gen_pulses(input int ch, input int n, input int lo, input int hi,
                              input bit glitchy);
        int p = lo;
        for (int k = 0; k < n; k++) begin
            int h = int'($urandom_range(5, DEBN));
            int l = int'($urandom_range(9, 3));
            if (p + h + l + 13 > hi) break;
            for (int t = 0; t < h; t++) wave[p + t][ch] = 1'b1;
            p += h + l;
            if (glitchy && ($urandom_range(1, 0) == 1)) begin
                wave[p][ch] = 1'b1;
                p += 1 + int'($urandom_range(9, 3));
            end
        end
    endtask

    task automatic gen_glitches(input int ch, input int n, input int lo);
        int p = lo;
        for (int k = 0; k < n; k++) begin
            wave[p][ch] = 1'b1;
            p += 1 + int'($urandom_range(7, 3));
        end
    endtask

    // Drive wave[0..ncyc-1], one entry per clock; report the first cycle rpm_valid is seen.
    task automatic run_window(input int ncyc, output int first_valid);
        first_valid = 0;
        start_lvl   = last_lvl;
        for (int j = 0; j < ncyc; j++) begin
            tach = wave[j];
            @(posedge clk);
            #1;
            if (rpm_valid && (first_valid == 0)) first_valid = j + 1;
        end
        last_lvl = wave[ncyc - 1];
    endtask

    // A pulse is any high run of at least DEB cycles that starts inside the window.
    function automatic void model_close();
        for (int c = 0; c < NMOT; c++) begin
            int n     = 0;
            int run   = 0;
            bit carry = start_lvl[c];
            for (int j = 0; j < WIN; j++) begin
                if (wave[j][c]) begin
                    run++;
                end else begin
                    if (run >= DEBN && !carry) n++;
                    run   = 0;
                    carry = 1'b0;
                end
            end
            if (run >= DEBN && !carry) n++;
            exp_rpm[c] = (n * RPC > RMAX) ? RMAX : n * RPC;
            if (n == 0) zero_run[c] = (zero_run[c] < SW) ? zero_run[c] + 1 : SW;
            else zero_run[c] = 0;
            exp_stall[c] = (zero_run[c] == SW);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tach = NMOT'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if (rpm_valid !== 1'b0 || stall !== '0)
                $display("FAIL reset_ctrl: cyc %0d valid=%b stall=%b want 0/0", k, rpm_valid, stall);
            else n_pass++;
        end
        tach = '0;
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < NMOT; c++) begin
            n_checks++;
            if (int'(rpm_sense[c]) !== 0)
                $display("FAIL reset_rpm[%0d]: got %0d want 0", c, rpm_sense[c]);
            else n_pass++;
        end
    endtask

    task automatic test_first_valid();
        int fv;
        int waited = 0;
        reset = 1'b0;
        clear_wave();
        gen_pulses(CH_L, 100, 10, 2990, 1'b0);
        run_window(3000, fv);
        n_checks++;
        if (fv !== 0) $display("FAIL partial_no_valid: valid at %0d want none", fv);
        else n_pass++;
        // Reset mid-window: the partial count must be discarded.
        reset = 1'b1;
        tach  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < NMOT; c++) begin
            zero_run[c] = 0;
            exp_rpm[c]  = 0;
        end
        exp_stall = '0;
        last_lvl  = '0;
        start_lvl = '0;
        clear_wave();
        while (waited < 9000) begin
            @(posedge clk);
            #1;
            waited++;
            if (rpm_valid) break;
        end
        n_checks++;
        if (waited !== WIN) $display("FAIL first_valid_latency: got %0d want %0d", waited, WIN);
        else n_pass++;
        model_close();
        n_checks++;
        if (int'(rpm_sense[CH_L]) !== 0)
            $display("FAIL reset_discard: rpm0 got %0d want 0", rpm_sense[CH_L]);
        else n_pass++;
        for (int c = 0; c < NMOT; c++) begin
            n_checks += 2;
            if (int'(rpm_sense[c]) !== exp_rpm[c])
                $display("FAIL first_rpm[%0d]: got %0d want %0d", c, rpm_sense[c], exp_rpm[c]);
            else n_pass++;
            if (stall[c] !== exp_stall[c])
                $display("FAIL first_stall[%0d]: got %b want %b", c, stall[c], exp_stall[c]);
            else n_pass++;
        end
    endtask

    task automatic test_rate();
        int fv;
        clear_wave();
        for (int j = 0; j < WIN; j++) wave[j][CH_L] = ((j / 20) % 2) == 1;
        run_window(WIN, fv);
        n_checks++;
        if (fv !== WIN) $display("FAIL rate_valid_time: got %0d want %0d", fv, WIN);
        else n_pass++;
        model_close();
        n_checks++;
        if (int'(rpm_sense[CH_L]) !== 5000)
            $display("FAIL rate_rpm0: got %0d want 5000", rpm_sense[CH_L]);
        else n_pass++;
        for (int c = 0; c < NMOT; c++) begin
            n_checks += 2;
            if (int'(rpm_sense[c]) !== exp_rpm[c])
                $display("FAIL rate_rpm[%0d]: got %0d want %0d", c, rpm_sense[c], exp_rpm[c]);
            else n_pass++;
            if (stall[c] !== exp_stall[c])
                $display("FAIL rate_stall[%0d]: got %b want %b", c, stall[c], exp_stall[c]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int fv;
        clear_wave();
        gen_pulses(CH_F, 250, 10, 7975, 1'b0);
        run_window(WIN, fv);
        n_checks++;
        if (fv !== WIN) $display("FAIL sat_valid_time: got %0d want %0d", fv, WIN);
        else n_pass++;
        model_close();
        n_checks += 2;
        if (int'(rpm_sense[CH_F]) !== 5500)
            $display("FAIL sat_rpm2: got %0d want 5500", rpm_sense[CH_F]);
        else n_pass++;
        // Motor 3 has now been idle for three windows since reset.
        if (stall[CH_RV] !== 1'b1) $display("FAIL stall3_set: got %b want 1", stall[CH_RV]);
        else n_pass++;
        for (int c = 0; c < NMOT; c++) begin
            n_checks += 2;
            if (int'(rpm_sense[c]) !== exp_rpm[c])
                $display("FAIL sat_rpm[%0d]: got %0d want %0d", c, rpm_sense[c], exp_rpm[c]);
            else n_pass++;
            if (stall[c] !== exp_stall[c])
                $display("FAIL sat_stall[%0d]: got %b want %b", c, stall[c], exp_stall[c]);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int fv;
        clear_wave();
        gen_glitches(CH_RT, 300, 10);
        for (int t = 100; t < 104; t++) wave[t][CH_RV] = 1'b1;
        run_window(WIN, fv);
        model_close();
        n_checks += 4;
        if (fv !== WIN) $display("FAIL glitch_valid_time: got %0d want %0d", fv, WIN);
        else n_pass++;
        if (int'(rpm_sense[CH_RT]) !== 0)
            $display("FAIL glitch_rpm1: got %0d want 0", rpm_sense[CH_RT]);
        else n_pass++;
        if (int'(rpm_sense[CH_RV]) !== 25)
            $display("FAIL stall3_pulse_rpm: got %0d want 25", rpm_sense[CH_RV]);
        else n_pass++;
        if (stall[CH_RV] !== 1'b0) $display("FAIL stall3_clear: got %b want 0", stall[CH_RV]);
        else n_pass++;
        for (int c = 0; c < NMOT; c++) begin
            n_checks += 2;
            if (int'(rpm_sense[c]) !== exp_rpm[c])
                $display("FAIL glitch_rpm[%0d]: got %0d want %0d", c, rpm_sense[c], exp_rpm[c]);
            else n_pass++;
            if (stall[c] !== exp_stall[c])
                $display("FAIL glitch_stall[%0d]: got %b want %b", c, stall[c], exp_stall[c]);
            else n_pass++;
        end
        clear_wave();
        for (int k = 0; k < 10; k++) begin
            for (int t = 0; t < 3; t++) wave[10 + k * 10 + t][CH_RT] = 1'b1;
        end
        gen_pulses(CH_F, int'($urandom_range(200, 20)), 200, 7975, 1'b1);
        run_window(WIN, fv);
        model_close();
        n_checks += 2;
        if (fv !== WIN) $display("FAIL wide_valid_time: got %0d want %0d", fv, WIN);
        else n_pass++;
        if (int'(rpm_sense[CH_RT]) !== 250)
            $display("FAIL wide_rpm1: got %0d want 250", rpm_sense[CH_RT]);
        else n_pass++;
        for (int c = 0; c < NMOT; c++) begin
            n_checks += 2;
            if (int'(rpm_sense[c]) !== exp_rpm[c])
                $display("FAIL wide_rpm[%0d]: got %0d want %0d", c, rpm_sense[c], exp_rpm[c]);
            else n_pass++;
            if (stall[c] !== exp_stall[c])
                $display("FAIL wide_stall[%0d]: got %b want %b", c, stall[c], exp_stall[c]);
            else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        int fv;
        clear_wave();
        gen_pulses(CH_L, 100, 10, 3900, 1'b0);
        run_window(4000, fv);
        n_checks++;
        if (fv !== 0) $display("FAIL en_pre_drop_valid: valid at %0d want none", fv);
        else n_pass++;
        en = 1'b0;
        clear_wave();
        gen_pulses(CH_L, 20, 0, 400, 1'b0);
        gen_pulses(CH_F, 15, 0, 400, 1'b1);
        run_window(500, fv);
        n_checks++;
        if (fv !== 0) $display("FAIL en_low_valid: valid at %0d want none", fv);
        else n_pass++;
        for (int c = 0; c < NMOT; c++) begin
            n_checks += 2;
            if (int'(rpm_sense[c]) !== exp_rpm[c])
                $display("FAIL en_low_hold_rpm[%0d]: got %0d want %0d", c, rpm_sense[c], exp_rpm[c]);
            else n_pass++;
            if (stall[c] !== exp_stall[c])
                $display("FAIL en_low_hold_stall[%0d]: got %b want %b", c, stall[c], exp_stall[c]);
            else n_pass++;
            zero_run[c] = 0;
        end
        en = 1'b1;
        clear_wave();
        gen_pulses(CH_L, 40, 10, 7975, 1'b0);
        gen_pulses(CH_RT, int'($urandom_range(150, 0)), 10, 7975, 1'b1);
        run_window(WIN, fv);
        model_close();
        n_checks += 2;
        if (fv !== WIN) $display("FAIL en_rise_valid_time: got %0d want %0d", fv, WIN);
        else n_pass++;
        if (int'(rpm_sense[CH_L]) !== 1000)
            $display("FAIL en_rise_rpm0: got %0d want 1000", rpm_sense[CH_L]);
        else n_pass++;
        for (int c = 0; c < NMOT; c++) begin
            n_checks += 2;
            if (int'(rpm_sense[c]) !== exp_rpm[c])
                $display("FAIL en_rise_rpm[%0d]: got %0d want %0d", c, rpm_sense[c], exp_rpm[c]);
            else n_pass++;
            if (stall[c] !== exp_stall[c])
                $display("FAIL en_rise_stall[%0d]: got %b want %b", c, stall[c], exp_stall[c]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int fv;
        for (int w = 0; w < 2; w++) begin
            clear_wave();
            for (int c = 0; c < NMOT; c++) begin
                if ($urandom_range(3, 0) != 0)
                    gen_pulses(c, int'($urandom_range(260, 1)), 10, 7975, 1'b1);
            end
            run_window(WIN, fv);
            model_close();
            n_checks++;
            if (fv !== WIN) $display("FAIL b2b_valid_time: win %0d got %0d want %0d", w, fv, WIN);
            else n_pass++;
            for (int c = 0; c < NMOT; c++) begin
                n_checks += 2;
                if (int'(rpm_sense[c]) !== exp_rpm[c])
                    $display("FAIL b2b_rpm[%0d]: win %0d got %0d want %0d", c, w, rpm_sense[c],
                             exp_rpm[c]);
                else n_pass++;
                if (stall[c] !== exp_stall[c])
                    $display("FAIL b2b_stall[%0d]: win %0d got %b want %b", c, w, stall[c],
                             exp_stall[c]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int c = 0; c < NMOT; c++) begin
            exp_rpm[c]  = 0;
            zero_run[c] = 0;
        end
        test_reset();
        test_first_valid();
        test_rate();
        test_saturation();
        test_glitch();
        test_enable_drop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
